// File: rtl/bcd_seg7_scan.sv
// 8-digit common-anode 7-segment scanner fed by packed BCD.
// Double-buffered input swaps only on frame wrap; optional leading-zero blanking.
module bcd_seg7_scan #(
    parameter int unsigned CLK_DIV  = 100000,
    parameter int unsigned N_DIGITS = 8,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   bcd_in,
    input  logic [N_DIGITS-1:0]     dp_mask,
    output logic [N_DIGITS-1:0]     an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IW = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*N_DIGITS-1:0]   shadow;
    logic [4*N_DIGITS-1:0]   active;
    logic                    pending;

    logic                    tick;
    logic                    wrap;
    logic [3:0]              code;
    logic [N_DIGITS-1:0]     nz_above;
    logic                    blank;
    logic [6:0]              seg_next;

    function automatic logic [6:0] decode(input logic [3:0] c);
        logic [6:0] s;
        case (c)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        tick = en && (cnt == CNT_LAST);
        wrap = tick && (idx == IDX_LAST);
    end

    // nz_above[d] is set when any digit d..N-1 of the active word is nonzero
    always_comb begin
        nz_above = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            int unsigned d;
            d = N_DIGITS - 1 - i;
            if (d == N_DIGITS - 1)
                nz_above[d] = |active[4*d +: 4];
            else
                nz_above[d] = nz_above[d+1] | (|active[4*d +: 4]);
        end
    end

    always_comb begin
        code  = active[4*idx +: 4];
        blank = (BLANK_LZ != 0) && (idx != '0) && !nz_above[idx];
        seg_next = blank ? 7'h7F : decode(code);
    end

    // Prescaler and digit index hold while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (en) begin
            if (tick) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Shadow/active buffer; a load landing on the wrap edge bypasses the shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (load)
                shadow <= bcd_in;
            if (wrap) begin
                if (load)
                    active <= bcd_in;
                else if (pending)
                    active <= shadow;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            seg        <= '1;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (en) begin
                an  <= ~(N_DIGITS'(1) << idx);
                seg <= seg_next;
                dp  <= ~dp_mask[idx];
            end else begin
                an  <= '1;
                seg <= '1;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Randomized bench for bcd_seg7_scan against a digit-level reference model.
// Two instances share stimulus: one with leading-zero blanking, one without.
module tb_bcd_seg7_scan;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [31:0] bcd_in;
    logic [7:0]  dp_mask;

    logic [7:0]  an_b, an_n;
    logic [6:0]  seg_b, seg_n;
    logic        dp_b, dp_n;
    logic        fd_b, fd_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_seg7_scan #(.CLK_DIV(DIV), .N_DIGITS(8), .BLANK_LZ(1)) u_blank (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .bcd_in(bcd_in),
        .dp_mask(dp_mask), .an(an_b), .seg(seg_b), .dp(dp_b), .frame_done(fd_b)
    );

    bcd_seg7_scan #(.CLK_DIV(DIV), .N_DIGITS(8), .BLANK_LZ(0)) u_noblank (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .bcd_in(bcd_in),
        .dp_mask(dp_mask), .an(an_n), .seg(seg_n), .dp(dp_n), .frame_done(fd_n)
    );

    // ---------------- reference model ----------------
    int unsigned m_cnt, m_idx;
    longint unsigned m_active, m_shadow;
    bit          m_pend;
    logic [7:0]  e_an;
    logic [6:0]  e_seg_b, e_seg_n;
    logic        e_dp, e_fd;

    logic [6:0] seg_tab [16];
    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    end

    function automatic logic [6:0] ref_seg(input longint unsigned word,
                                           input int unsigned d, input bit blank_lz);
        longint unsigned upper;
        upper = word >> (4 * d);
        if (blank_lz && d > 0 && upper == 0)
            return 7'h7F;
        return seg_tab[upper % 16];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_idx <= 0; m_active <= 0; m_shadow <= 0; m_pend <= 0;
            e_an <= 8'hFF; e_seg_b <= 7'h7F; e_seg_n <= 7'h7F; e_dp <= 1'b1; e_fd <= 1'b0;
        end else begin
            bit at_wrap;
            at_wrap = en && m_cnt == DIV - 1 && m_idx == 7;
            e_fd <= at_wrap;
            if (en) begin
                e_an    <= 8'(255 - (1 << m_idx));
                e_seg_b <= ref_seg(m_active, m_idx, 1'b1);
                e_seg_n <= ref_seg(m_active, m_idx, 1'b0);
                e_dp    <= !dp_mask[m_idx];
                m_cnt   <= (m_cnt + 1) % DIV;
                if (m_cnt == DIV - 1) m_idx <= (m_idx + 1) % 8;
            end else begin
                e_an <= 8'hFF; e_seg_b <= 7'h7F; e_seg_n <= 7'h7F; e_dp <= 1'b1;
            end
            if (load) m_shadow <= bcd_in;
            if (at_wrap) begin
                m_active <= load ? longint'(bcd_in) : (m_pend ? m_shadow : m_active);
                m_pend   <= 0;
            end else if (load) begin
                m_pend <= 1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("an",        32'(an_b),  32'(e_an));
        check("seg_blank", 32'(seg_b), 32'(e_seg_b));
        check("seg_full",  32'(seg_n), 32'(e_seg_n));
        check("dp",        32'(dp_b),  32'(e_dp));
        check("frame_done",32'(fd_b),  32'(e_fd));
        check("an_full",   32'(an_n),  32'(e_an));
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            check_outputs();
        end
    endtask

    // Advance until the model reaches the given digit/count, checking each cycle
    task automatic wait_for(input int unsigned idx, input int unsigned cnt);
        int budget;
        budget = 200;
        while (!(m_idx == idx && m_cnt == cnt) && budget > 0) begin
            run(1);
            budget--;
        end
        if (budget == 0) check("wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_load(input logic [31:0] v);
        load = 1'b1; bcd_in = v;
        run(1);
        load = 1'b0;
    endtask

    function automatic logic [31:0] rand_bcd();
        logic [31:0] v;
        int unsigned nz;
        v  = '0;
        nz = $urandom_range(0, 8);
        for (int unsigned d = 0; d < nz; d++)
            v[4*d +: 4] = ($urandom % 10 == 0) ? 4'($urandom_range(10, 15))
                                               : 4'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0; bcd_in = '0; dp_mask = '0;
        repeat (2) @(negedge clk);
        check("rst_an",  32'(an_b),  32'hFF);
        check("rst_seg", 32'(seg_b), 32'h7F);
        check("rst_dp",  32'(dp_b),  32'h1);
        check("rst_fd",  32'(fd_b),  32'h0);
        rst_n = 1'b1; en = 1'b1;

        // Two frames of the all-zero display
        run(70);

        // Load mid-frame at digit 3: old value finishes the frame
        wait_for(3, 1);
        pulse_load(32'h0001_2345);
        run(80);

        // Load on the wrap edge bypasses the shadow
        wait_for(7, DIV - 1);
        pulse_load(32'h8765_4321);
        run(70);

        // Invalid code; the non-blanking instance shows the zeros
        pulse_load(32'h0000_00A0);
        run(70);

        // Decimal point and enable hold at digit 5
        dp_mask = 8'h04;
        run(40);
        wait_for(5, 2);
        en = 1'b0;
        run(10);
        check("dark_an", 32'(an_b), 32'hFF);
        en = 1'b1;
        run(40);

        // Async reset mid-frame with a pending load
        wait_for(2, 1);
        pulse_load(32'h9999_9999);
        #1 rst_n = 1'b0;
        #1;
        check("async_an",  32'(an_b),  32'hFF);
        check("async_seg", 32'(seg_b), 32'h7F);
        check("async_dp",  32'(dp_b),  32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        run(80);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            en   = ($urandom % 16) != 0;
            load = ($urandom % 12) == 0;
            if (load) bcd_in = rand_bcd();
            if ($urandom % 40 == 0) dp_mask = 8'($urandom);
            run(1);
        end
        load = 1'b0;
        run(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
